// File: rtl/ex_stage.sv
// ex_stage: execute stage of the integer pipeline.
//   Logic, shift, ADDU/SUBU and SLT results are combinational in the same cycle.
//   DIV/DIVU use an iterative radix-2 restoring divider. The divider takes one
//   IDLE cycle, DATA_W BUSY cycles and one DONE cycle. stall_req_o holds the
//   upstream stages until the quotient is ready.
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   alusel_i, aluop_i   result class and operation from ID/EX
//   reg1_data_i         operand 1 / dividend / shift amount (low bits)
//   reg2_data_i         operand 2 / divisor / shift source
//   waddr_i, wreg_i     destination register and write enable from ID
//   annul_i             flush; aborts any divide in progress
//   waddr_o, wreg_o     destination and write enable to EX/MEM and forwarding
//   wdata_o             result (quotient for DIV/DIVU)
//   div_rem_o           remainder; valid with wreg_o in the DIV/DIVU DONE cycle
//   stall_req_o         hold PC, IF/ID and ID/EX this cycle
module ex_stage #(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  DIV0_QUOT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        alusel_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic [4:0]        waddr_i,
  input  logic              wreg_i,
  input  logic              annul_i,
  output logic [4:0]        waddr_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] div_rem_o,
  output logic              stall_req_o
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   quot_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dvs_q;
  logic                neg_quot;
  logic                neg_rem;

  logic [SH_W-1:0]     shamt;
  logic                slt;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ok;

  logic                is_div;
  logic                is_sdiv;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;

  logic [DATA_W:0]     shifted;
  logic                ge;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quot_step;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Single-cycle datapath
  assign shamt = reg1_data_i[SH_W-1:0];
  assign slt   = $signed(reg1_data_i) < $signed(reg2_data_i);

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b0;
    case (alusel_i)
      SEL_LOGIC: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_AND:  alu_res = reg1_data_i & reg2_data_i;
          OP_OR:   alu_res = reg1_data_i | reg2_data_i;
          OP_XOR:  alu_res = reg1_data_i ^ reg2_data_i;
          OP_NOR:  alu_res = ~(reg1_data_i | reg2_data_i);
          default: alu_ok  = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_SLL:  alu_res = reg2_data_i << shamt;
          OP_SRL:  alu_res = reg2_data_i >> shamt;
          OP_SRA:  alu_res = $unsigned($signed(reg2_data_i) >>> shamt);
          default: alu_ok  = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_ADDU: alu_res = reg1_data_i + reg2_data_i;
          OP_SUBU: alu_res = reg1_data_i - reg2_data_i;
          OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
          default: alu_ok  = 1'b0;
        endcase
      end
      default: begin
        alu_res = '0;
        alu_ok  = 1'b0;
      end
    endcase
  end

  // Divider operand preparation
  assign is_div  = (alusel_i == SEL_ARITH) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
  assign is_sdiv = (aluop_i == OP_DIV);
  assign a_neg   = is_sdiv && reg1_data_i[DATA_W-1];
  assign b_neg   = is_sdiv && reg2_data_i[DATA_W-1];
  assign a_abs   = a_neg ? -reg1_data_i : reg1_data_i;
  assign b_abs   = b_neg ? -reg2_data_i : reg2_data_i;

  // One restoring step. quot_q holds the unconsumed dividend bits in its top
  // and the new quotient bits in its bottom. The partial remainder stays below
  // the divisor, so only the trial compare needs the extra bit.
  assign shifted   = {rem_q, quot_q[DATA_W-1]};
  assign ge        = shifted >= {1'b0, dvs_q};
  assign rem_step  = ge ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
  assign quot_step = {quot_q[DATA_W-2:0], ge};

  assign quot_fix  = neg_quot ? -quot_q : quot_q;
  assign rem_fix   = neg_rem  ? -rem_q  : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (annul_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            if (reg2_data_i == '0) begin
              // Divide-by-zero skips the iteration. The raw dividend is the
              // remainder, so no sign fix-up is applied.
              quot_q   <= DIV0_QUOT;
              rem_q    <= reg1_data_i;
              neg_quot <= 1'b0;
              neg_rem  <= 1'b0;
              state    <= S_DONE;
            end else begin
              quot_q   <= a_abs;
              rem_q    <= '0;
              dvs_q    <= b_abs;
              count    <= '0;
              neg_quot <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              state    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          quot_q <= quot_step;
          rem_q  <= rem_step;
          count  <= count + 1'b1;
          if (count == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is asserted. annul_i suppresses
  // both the stall and the write in the same cycle.
  always_comb begin
    waddr_o     = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    div_rem_o   = '0;
    stall_req_o = 1'b0;
    if (rst) begin
      waddr_o = waddr_i;
      case (state)
        S_IDLE: begin
          if (is_div) begin
            stall_req_o = !annul_i;
          end else begin
            wdata_o = alu_res;
            wreg_o  = wreg_i && alu_ok && !annul_i;
          end
        end
        S_BUSY: stall_req_o = !annul_i;
        S_DONE: begin
          wdata_o   = quot_fix;
          div_rem_o = rem_fix;
          wreg_o    = wreg_i && !annul_i;
        end
        default: begin
          wreg_o      = 1'b0;
          stall_req_o = 1'b0;
        end
      endcase
    end
  end

endmodule
